sram_like_mem_slave: RTL and testbench
======================================

# sram_like_mem_slave

Responder end of the sram-like handshake used by the CPU's instruction and data bridges. It accepts `req`/`addr_ok` address phases, queues up to `QDEPTH` outstanding transactions, and returns one `data_ok` per transaction, in order, after a programmable latency. Transactions are served from an internal word-organised memory. It sits in the SoC testbench and simulation top as the memory model behind the inst/data sram-like ports, and it can also serve as an on-chip scratch RAM.

## Interface
Parameters:
- `ADDR_W`, 12: word-address bits. Memory holds 2^ADDR_W 32-bit words.
- `LATENCY`, 2: minimum cycles from address acceptance to `data_ok`. Legal values are 1 and above.
- `QDEPTH`, 2: maximum outstanding accepted-but-unanswered transactions. Legal values are 1 and above.

Ports:
- `clk`, in, 1: clock. All state updates on the rising edge.
- `resetn`, in, 1: asynchronous, active-low reset.
- `req`, in, 1: request valid.
- `wr`, in, 1: 1 = write, 0 = read.
- `size`, in, 2: 0 = byte, 1 = halfword, 2 = word; 3 is treated as word.
- `addr`, in, 32: byte address.
- `wdata`, in, 32: write data, already lane-aligned.
- `addr_ok`, out, 1: address phase accepted this cycle.
- `data_ok`, out, 1: one transaction completes this cycle.
- `rdata`, out, 32: read data, valid only in a read's `data_ok` cycle.

## Operation
- **Queue.** The block holds a circular FIFO of `QDEPTH` entries `{wr, size, addr, wdata}`.
  - Read and write pointers wrap modulo `QDEPTH`.
  - An occupancy counter runs from 0 to `QDEPTH`.
- **Acceptance.**
  - `addr_ok = resetn & req & (count < QDEPTH)`, combinational.
  - The transaction is pushed at the edge closing a cycle where `req & addr_ok` is high.
  - When full, `addr_ok` is 0 even if a pop happens that cycle. There is no bypass.
- **Head timer `cnt`.**
  - Width is clog2(LATENCY)+1.
  - It clears to 0 whenever a new entry becomes head, which happens on a push into an empty queue or on a pop with `count > 1`.
  - Otherwise it increments while the head is valid and `data_ok` = 0.
- **Completion.**
  - `data_ok = head_valid & (cnt == LATENCY-1)`, a single-cycle pulse per entry.
  - The head is popped at the edge closing the `data_ok` cycle.
- **Reads.** In the `data_ok` cycle, `rdata` = `mem[head.addr[ADDR_W+1:2]]`, the full word regardless of `size`. `rdata` is 0 in every other cycle and for writes.
- **Writes.** These commit at the edge closing `data_ok`, using byte strobes:
  - size 0: lane `addr[1:0]`.
  - size 1: lanes {`addr[1]`*2, `addr[1]`*2+1}; `addr[0]` is ignored.
  - size 2 or 3: all 4 lanes; `addr[1:0]` is ignored.
- **Ordering.** Completion is strictly in acceptance order. A read queued behind a write to the same word returns the written data.
- **Address range.** Address bits above `ADDR_W+1` are ignored, so addresses alias modulo 2^(ADDR_W+2) bytes.
- **Push and pop in the same cycle.** These are legal: `count` is unchanged and the pointers both advance.

## Timing
- **Reset.** While `resetn` = 0:
  - `addr_ok` = 0, `data_ok` = 0, `rdata` = 0.
  - Queue is emptied, pointers = 0, `cnt` = 0.
  - Memory contents are not reset.
- **Reset mid-operation.** All outstanding transactions are dropped with no `data_ok`. A pending write is not committed.
- **Single transaction, queue empty.** Accept in cycle T; the entry is valid from T+1 with `cnt` = 0; `data_ok` is high in cycle T+LATENCY.
- **Back-to-back transactions.** The next entry's `data_ok` comes LATENCY cycles after the previous `data_ok`.
  - With LATENCY = 1, throughput is one completion per cycle.
  - With LATENCY = 1 and the queue empty, `data_ok` is high in the cycle after acceptance, never in the same cycle.
- **Full queue.** `addr_ok` drops in the cycle `count` = `QDEPTH`. It reasserts, if `req` is held, in the cycle after a pop.
- **Requester withdrawal.** The requester may drop `req` at any time before `addr_ok`; nothing is queued.

## Test plan
- **Reset values.** Hold `resetn` = 0 with `req` = 1 → `addr_ok`, `data_ok` and `rdata` all stay 0. Release → `addr_ok` = 1 in the first cycle.
- **Write then read, LATENCY = 2.**
  - Word write `addr`=0x10, `wdata`=0xDEADBEEF accepted at T → `data_ok` at T+2.
  - Read of 0x10 accepted at T+1 → `data_ok` at T+4 with `rdata`=0xDEADBEEF.
- **Byte and halfword lanes.** With word 0x20 = 0x00000000:
  - byte write `addr`=0x22, `wdata`=0x00AB0000 → read returns 0x00AB0000.
  - then halfword write `addr`=0x20, `wdata`=0x00001234 → read returns 0x00AB1234.
- **Queue full, QDEPTH = 2.**
  - Hold `req` for reads at 0x0, 0x4, 0x8 → `addr_ok` in the first two cycles, 0 in the third.
  - Third request accepted in the cycle after the first `data_ok`.
  - Three `data_ok` pulses, in order.
- **LATENCY = 1 streaming.** 8 consecutive reads with `req` held → `data_ok` high 8 consecutive cycles, starting one cycle after the first `addr_ok`; `rdata` matches each address in order.
- **Reset mid-flight.**
  - Write 0x40 := 0x11111111 accepted; assert `resetn` = 0 before its `data_ok` → no `data_ok`.
  - After release, read 0x40 → returns the old contents, not 0x11111111.

Source files
------------

// File: rtl/sram_like_mem_slave.sv
// sram_like_mem_slave: responder for the sram-like req/addr_ok/data_ok handshake.
// Accepts up to QDEPTH outstanding transactions and answers them in order after
// at least LATENCY cycles, serving them from an internal word-organised memory.
module sram_like_mem_slave #(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned QDEPTH  = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int unsigned PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(QDEPTH + 1);
  localparam int unsigned TMR_W = $clog2(LATENCY) + 1;
  localparam int unsigned MA_W  = ADDR_W + 2;
  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef struct packed {
    logic             wr;
    logic [1:0]       size;
    logic [MA_W-1:0]  addr;
    logic [31:0]      wdata;
  } txn_t;

  txn_t              q [QDEPTH];
  logic [31:0]       mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count;
  logic [TMR_W-1:0]  cnt;

  txn_t              head;
  logic              head_valid;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] head_word;
  logic [3:0]        strb;
  logic              unused_addr_hi;

  // Address bits above the memory range alias and are intentionally dropped.
  assign unused_addr_hi = ^addr[31:MA_W];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(QDEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Handshake decode, completion pulse and read data path.
  always_comb begin
    head       = q[rd_ptr];
    head_valid = (count != '0);
    addr_ok    = resetn & req & (count < CNT_W'(QDEPTH));
    push       = addr_ok;
    data_ok    = head_valid & (cnt == TMR_W'(LATENCY - 1));
    pop        = data_ok;
    head_word  = head.addr[MA_W-1:2];
    rdata      = (data_ok && !head.wr) ? mem[head_word] : '0;
  end

  // Byte-lane strobes for the head write.
  always_comb begin
    strb = 4'b1111;
    case (head.size)
      2'd0:    strb = 4'b0001 << head.addr[1:0];
      2'd1:    strb = head.addr[1] ? 4'b1100 : 4'b0011;
      default: strb = 4'b1111;
    endcase
  end

  // Queue pointers, occupancy and head timer.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      // Any pop or a push into an empty queue presents a fresh head.
      if (pop || (push && count == '0)) cnt <= '0;
      else if (head_valid)              cnt <= cnt + TMR_W'(1);
    end
  end

  // Transaction storage; contents are only meaningful between push and pop.
  always_ff @(posedge clk) begin
    if (push) q[wr_ptr] <= '{wr: wr, size: size, addr: addr[MA_W-1:0], wdata: wdata};
  end

  // Write commit at the completion edge, lane by lane.
  always_ff @(posedge clk) begin
    if (pop && head.wr) begin
      for (int b = 0; b < 4; b++) begin
        if (strb[b]) mem[head_word][8*b +: 8] <= head.wdata[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_sram_like_mem_slave.sv
// Bench for sram_like_mem_slave: directed vectors, corner sequences and a
// randomized run checked against a transaction-level model.
module tb_sram_like_mem_slave;

  localparam int unsigned LAT_A = 2;
  localparam int unsigned QD_A  = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_a, wr_a, addr_ok_a, data_ok_a;
  logic [1:0]  size_a;
  logic [31:0] addr_a, wdata_a, rdata_a;
  logic        req_b, wr_b, addr_ok_b, data_ok_b;
  logic [1:0]  size_b;
  logic [31:0] addr_b, wdata_b, rdata_b;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  sram_like_mem_slave #(.ADDR_W(12), .LATENCY(LAT_A), .QDEPTH(QD_A)) dut (
    .clk(clk), .resetn(resetn), .req(req_a), .wr(wr_a), .size(size_a),
    .addr(addr_a), .wdata(wdata_a), .addr_ok(addr_ok_a), .data_ok(data_ok_a),
    .rdata(rdata_a)
  );

  sram_like_mem_slave #(.ADDR_W(12), .LATENCY(1), .QDEPTH(2)) dut_b (
    .clk(clk), .resetn(resetn), .req(req_b), .wr(wr_b), .size(size_b),
    .addr(addr_b), .wdata(wdata_b), .addr_ok(addr_ok_b), .data_ok(data_ok_b),
    .rdata(rdata_b)
  );

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          due;
  } ent_t;

  vec_t        vt [12];
  ent_t        mq [$];
  logic [31:0] mm [16];
  int          last_due = -100;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One cycle on instance A: drive after the rising edge, return at the falling edge.
  task automatic drive_a(input logic r, input logic w, input logic [1:0] s,
                         input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    req_a = r; wr_a = w; size_a = s; addr_a = a; wdata_a = d;
    cyc++;
    @(negedge clk);
  endtask

  task automatic drive_b(input logic r, input logic w, input logic [1:0] s,
                         input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    req_b = r; wr_b = w; size_b = s; addr_b = a; wdata_b = d;
    @(negedge clk);
  endtask

  // Isolated transaction on A: wait for acceptance, then for completion.
  task automatic do_txn(input logic w, input logic [1:0] s, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp, input string name);
    int k;
    k = 0;
    drive_a(1'b1, w, s, a, d);
    while (!addr_ok_a && k < 20) begin
      drive_a(1'b1, w, s, a, d);
      k++;
    end
    chk1({name, "_accept"}, addr_ok_a, 1'b1);
    k = 0;
    do begin
      drive_a(1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
      k++;
    end while (!data_ok_a && k < 20);
    chk32({name, "_latency"}, 32'(k), 32'(LAT_A));
    chk32({name, "_rdata"}, rdata_a, exp);
  endtask

  // Reference byte-lane merge written from the lane rules.
  function automatic logic [31:0] merge(input logic [31:0] old, input logic [1:0] s,
                                        input logic [1:0] lo, input logic [31:0] d);
    logic [31:0] r;
    logic        hit;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (s == 2'd0)      hit = (b == int'(lo));
      else if (s == 2'd1) hit = ((b / 2) == int'(lo[1]));
      else                hit = 1'b1;
      if (hit) r[8*b +: 8] = d[8*b +: 8];
    end
    return r;
  endfunction

  // One randomized cycle on A checked against the transaction model.
  task automatic rand_cycle(input logic r, input logic w, input logic [1:0] s,
                            input logic [31:0] a, input logic [31:0] d);
    logic        exp_aok, exp_dok;
    logic [31:0] exp_rd;
    ent_t        e;
    int          due;
    drive_a(r, w, s, a, d);
    exp_aok = r && (mq.size() < QD_A);
    exp_dok = (mq.size() > 0) && (mq[0].due == cyc);
    exp_rd  = (exp_dok && !mq[0].wr) ? mm[mq[0].addr[5:2]] : 32'd0;
    chk1("rand_addr_ok", addr_ok_a, exp_aok);
    chk1("rand_data_ok", data_ok_a, exp_dok);
    chk32("rand_rdata", rdata_a, exp_rd);
    if (exp_dok) begin
      e = mq.pop_front();
      if (e.wr) mm[e.addr[5:2]] = merge(mm[e.addr[5:2]], e.size, e.addr[1:0], e.wdata);
    end
    if (exp_aok) begin
      due = (cyc + int'(LAT_A) > last_due + int'(LAT_A)) ? cyc + int'(LAT_A)
                                                         : last_due + int'(LAT_A);
      mq.push_back('{wr: w, size: s, addr: a, wdata: d, due: due});
      last_due = due;
    end
  endtask

  initial begin
    vt[0]  = '{1'b1, 2'd0, 32'h0000_0022, 32'h00AB_0000, 32'h0};
    vt[1]  = '{1'b0, 2'd2, 32'h0000_0020, 32'h0,         32'h00AB_0000};
    vt[2]  = '{1'b1, 2'd1, 32'h0000_0020, 32'h0000_1234, 32'h0};
    vt[3]  = '{1'b0, 2'd2, 32'h0000_0020, 32'h0,         32'h00AB_1234};
    vt[4]  = '{1'b1, 2'd3, 32'h0000_0027, 32'h5566_7788, 32'h0};
    vt[5]  = '{1'b0, 2'd0, 32'h0000_0024, 32'h0,         32'h5566_7788};
    vt[6]  = '{1'b1, 2'd1, 32'h0000_0027, 32'hCAFE_0000, 32'h0};
    vt[7]  = '{1'b0, 2'd2, 32'h0000_0024, 32'h0,         32'hCAFE_7788};
    vt[8]  = '{1'b1, 2'd0, 32'h0000_0025, 32'h0000_9900, 32'h0};
    vt[9]  = '{1'b0, 2'd1, 32'h0000_0024, 32'h0,         32'hCAFE_9988};
    vt[10] = '{1'b0, 2'd2, 32'h0000_4024, 32'h0,         32'hCAFE_9988};
    vt[11] = '{1'b0, 2'd2, 32'h8000_0024, 32'h0,         32'hCAFE_9988};

    resetn = 1'b0;
    req_a = 1'b1; wr_a = 1'b0; size_a = 2'd2; addr_a = 32'h10; wdata_a = 32'h0;
    req_b = 1'b1; wr_b = 1'b0; size_b = 2'd2; addr_b = 32'h10; wdata_b = 32'h0;

    // Reset holds every output low even with req asserted.
    repeat (3) begin
      @(negedge clk);
      chk1("rst_addr_ok_a", addr_ok_a, 1'b0);
      chk1("rst_data_ok_a", data_ok_a, 1'b0);
      chk32("rst_rdata_a", rdata_a, 32'h0);
      chk1("rst_addr_ok_b", addr_ok_b, 1'b0);
    end
    @(posedge clk); #1;
    resetn = 1'b1; req_b = 1'b0; cyc++;
    @(negedge clk);
    chk1("release_addr_ok", addr_ok_a, 1'b1);
    drive_a(1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
    chk1("release_dok_early", data_ok_a, 1'b0);
    drive_a(1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
    chk1("release_dok", data_ok_a, 1'b1);

    // Overlapped write then read of the same word.
    drive_a(1'b1, 1'b1, 2'd2, 32'h10, 32'hDEAD_BEEF);
    chk1("wr10_aok", addr_ok_a, 1'b1);
    chk1("wr10_dok0", data_ok_a, 1'b0);
    drive_a(1'b1, 1'b0, 2'd2, 32'h10, 32'h0);
    chk1("rd10_aok", addr_ok_a, 1'b1);
    chk1("rd10_dok0", data_ok_a, 1'b0);
    drive_a(1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
    chk1("wr10_dok", data_ok_a, 1'b1);
    chk32("wr10_rdata", rdata_a, 32'h0);
    drive_a(1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
    chk1("rd10_gap", data_ok_a, 1'b0);
    drive_a(1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
    chk1("rd10_dok", data_ok_a, 1'b1);
    chk32("rd10_rdata", rdata_a, 32'hDEAD_BEEF);

    // Lane vectors.
    do_txn(1'b1, 2'd2, 32'h20, 32'h0, 32'h0, "clr20");
    for (int i = 0; i < 12; i++)
      do_txn(vt[i].wr, vt[i].size, vt[i].addr, vt[i].wdata, vt[i].exp_rdata,
             $sformatf("vec%0d", i));

    // Full queue with req held.
    do_txn(1'b1, 2'd2, 32'h0, 32'h0000_A000, 32'h0, "pre0");
    do_txn(1'b1, 2'd2, 32'h4, 32'h0000_A004, 32'h0, "pre4");
    do_txn(1'b1, 2'd2, 32'h8, 32'h0000_A008, 32'h0, "pre8");
    drive_a(1'b1, 1'b0, 2'd2, 32'h0, 32'h0);
    chk1("qf_aok0", addr_ok_a, 1'b1);
    drive_a(1'b1, 1'b0, 2'd2, 32'h4, 32'h0);
    chk1("qf_aok1", addr_ok_a, 1'b1);
    chk1("qf_dok1", data_ok_a, 1'b0);
    drive_a(1'b1, 1'b0, 2'd2, 32'h8, 32'h0);
    chk1("qf_full_aok", addr_ok_a, 1'b0);
    chk1("qf_dok_a", data_ok_a, 1'b1);
    chk32("qf_rd_a", rdata_a, 32'h0000_A000);
    drive_a(1'b1, 1'b0, 2'd2, 32'h8, 32'h0);
    chk1("qf_reaccept", addr_ok_a, 1'b1);
    chk1("qf_gap1", data_ok_a, 1'b0);
    drive_a(1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
    chk1("qf_dok_b", data_ok_a, 1'b1);
    chk32("qf_rd_b", rdata_a, 32'h0000_A004);
    drive_a(1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
    chk1("qf_gap2", data_ok_a, 1'b0);
    drive_a(1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
    chk1("qf_dok_c", data_ok_a, 1'b1);
    chk32("qf_rd_c", rdata_a, 32'h0000_A008);
    drive_a(1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
    chk1("qf_idle", data_ok_a, 1'b0);

    // LATENCY=1 streaming: eight writes then eight reads back-to-back.
    for (int i = 0; i < 8; i++) begin
      drive_b(1'b1, 1'b1, 2'd2, 32'h80 + 32'(4 * i), 32'hA500_0000 | 32'(i));
      chk1($sformatf("st_wr_aok%0d", i), addr_ok_b, 1'b1);
      chk1($sformatf("st_wr_dok%0d", i), data_ok_b, i > 0);
    end
    drive_b(1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
    chk1("st_wr_last", data_ok_b, 1'b1);
    drive_b(1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
    chk1("st_wr_idle", data_ok_b, 1'b0);
    for (int i = 0; i < 8; i++) begin
      drive_b(1'b1, 1'b0, 2'd2, 32'h80 + 32'(4 * i), 32'h0);
      chk1($sformatf("st_rd_aok%0d", i), addr_ok_b, 1'b1);
      chk1($sformatf("st_rd_dok%0d", i), data_ok_b, i > 0);
      chk32($sformatf("st_rd_data%0d", i), rdata_b,
            (i > 0) ? (32'hA500_0000 | 32'(i - 1)) : 32'h0);
    end
    drive_b(1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
    chk1("st_rd_last", data_ok_b, 1'b1);
    chk32("st_rd_last_data", rdata_b, 32'hA500_0007);
    drive_b(1'b0, 1'b0, 2'd0, 32'd0, 32'd0);
    chk1("st_rd_idle", data_ok_b, 1'b0);

    // Reset while a write is outstanding drops it uncommitted.
    do_txn(1'b1, 2'd2, 32'h40, 32'h0BAD_F00D, 32'h0, "pre40");
    drive_a(1'b1, 1'b1, 2'd2, 32'h40, 32'h1111_1111);
    chk1("mid_aok", addr_ok_a, 1'b1);
    @(posedge clk); #1;
    resetn = 1'b0; req_a = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk1("mid_rst_dok", data_ok_a, 1'b0);
    end
    @(posedge clk); #1;
    resetn = 1'b1; cyc++;
    @(negedge clk);
    chk1("mid_post_dok", data_ok_a, 1'b0);
    do_txn(1'b0, 2'd2, 32'h40, 32'h0, 32'h0BAD_F00D, "rd40");

    // Randomized traffic over a known 16-word window with aliasing upper bits.
    for (int i = 0; i < 16; i++) begin
      mm[i] = $urandom;
      do_txn(1'b1, 2'd2, 32'h100 + 32'(4 * i), mm[i], 32'h0, "init");
    end
    last_due = -100;
    for (int i = 0; i < 400; i++) begin
      rand_cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)),
                 32'h100 | 32'($urandom_range(0, 63)) | ($urandom & 32'hFFFF_C000),
                 $urandom);
    end
    for (int i = 0; i < 10; i++)
      if (mq.size() > 0) rand_cycle(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    chk32("rand_drain", 32'(mq.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
